// File: rtl/multiword_add_pkg.sv
// rtl/multiword_add_pkg.sv - shared types and overflow rule for the multiword add sequencer
package multiword_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } add_state_t;

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic ovf_rule(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/multiword_add_ctrl_if.sv
// rtl/multiword_add_ctrl_if.sv - operand and result handshake bundle for multiword_add_ctrl
interface multiword_add_ctrl_if #(
    parameter int W = 8,
    parameter int K = 4
);
    logic             valid_i;
    logic             ready_o;
    logic [W*K-1:0]   a_i;
    logic [W*K-1:0]   b_i;
    logic             c_i;
    logic             sub_i;
    logic             valid_o;
    logic             ready_i;
    logic [W*K-1:0]   sum_o;
    logic             c_o;
    logic             ovf_o;

    modport master (
        output valid_i, a_i, b_i, c_i, sub_i, ready_i,
        input  ready_o, valid_o, sum_o, c_o, ovf_o
    );

    modport slave (
        input  valid_i, a_i, b_i, c_i, sub_i, ready_i,
        output ready_o, valid_o, sum_o, c_o, ovf_o
    );
endinterface

// File: rtl/ripple_carry.sv
// rtl/ripple_carry.sv - N-bit ripple-carry adder built from a chain of full adders
module ripple_carry #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);
    logic [N:0] c;

    always_comb begin
        c[0] = ci;
        for (int i = 0; i < N; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = c[N];
endmodule

// File: rtl/multiword_add_ctrl.sv
// rtl/multiword_add_ctrl.sv - word-serial N=W*K add/subtract around one shared W-bit adder
module multiword_add_ctrl
    import multiword_add_pkg::*;
#(
    parameter int W = 8,
    parameter int K = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    multiword_add_ctrl_if.slave bus
);
    localparam int             N    = W * K;
    localparam int             CW   = $clog2(K);
    localparam logic [CW-1:0]  LAST = CW'(K - 1);

    add_state_t      state;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [N-1:0]    sum_q;
    logic            carry_q;
    logic            c_q;
    logic            ovf_q;
    logic            valid_q;

    logic [W-1:0]    a_w;
    logic [W-1:0]    b_w;
    logic [W-1:0]    s_w;
    logic            co_w;

    assign a_w = a_q[cnt*W +: W];
    assign b_w = b_q[cnt*W +: W];

    ripple_carry #(.N(W)) u_adder (
        .a  (a_w),
        .b  (b_w),
        .ci (carry_q),
        .s  (s_w),
        .co (co_w)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.valid_i) begin
                        // Subtraction is A + ~B + 1; the +1 rides in on the carry register.
                        a_q     <= bus.a_i;
                        b_q     <= bus.sub_i ? ~bus.b_i : bus.b_i;
                        carry_q <= bus.sub_i ? 1'b1 : bus.c_i;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_q[cnt*W +: W] <= s_w;
                    carry_q           <= co_w;
                    if (cnt == LAST) begin
                        c_q     <= co_w;
                        ovf_q   <= ovf_rule(a_w[W-1], b_w[W-1], s_w[W-1]);
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.ready_i) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o = (state == IDLE);
    assign bus.valid_o = valid_q;
    assign bus.sum_o   = sum_q;
    assign bus.c_o     = c_q;
    assign bus.ovf_o   = ovf_q;
endmodule
